// File: rtl/cv32e40p_pkg.sv
// Shared types and limits for the ALU writeback buffer.
package cv32e40p_pkg;

  // Upper bound on buffer depth.
  localparam int unsigned ALU_WB_DEPTH_MAX  = 8;
  // Storage width for the destination address field; narrower ADDR_W values are zero-extended.
  localparam int unsigned ALU_WB_ADDR_W_MAX = 16;

  typedef struct packed {
    logic [ALU_WB_ADDR_W_MAX-1:0] addr;
    logic [31:0]                  data;
    logic                         cmp;
  } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_entry_fifo.sv
// Circular entry store with read/write pointers and occupancy count.
module alu_wb_entry_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  alu_wb_entry_t wdata_i,
  output alu_wb_entry_t head_o,
  output alu_wb_entry_t tail_o,
  output logic [CntW-1:0] count_o
);

  alu_wb_entry_t mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] tail_ptr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next pointer and count values; flush restarts everything at slot 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (pop_i && !push_i) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the write pointer on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Youngest entry sits one slot behind the write pointer.
  assign tail_ptr = (wr_ptr_q == '0) ? PtrW'(DEPTH - 1) : wr_ptr_q - PtrW'(1);

  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = mem_q[tail_ptr];
  assign count_o = count_q;

endmodule

// File: rtl/alu_wb_buffer.sv
// Buffers ALU completions ahead of the register-file write port.
// Optional forwarding of the youngest entry is enabled by defining ALU_WB_FWD_EN.
module alu_wb_buffer
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 6,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  input  logic [31:0]       alu_result_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic              alu_cmp_i,
  output logic              alu_ready_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [31:0]       wb_wdata_o,
  output logic              wb_cmp_o,
  input  logic              wb_ready_i,
  output logic              fwd_valid_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [31:0]       fwd_data_o,
  output logic [CntW-1:0]   count_o
);

  localparam logic [1:0] StEmpty   = 2'd0;
  localparam logic [1:0] StPartial = 2'd1;
  localparam logic [1:0] StFull    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          push, pop;
  alu_wb_entry_t wr_entry, head_entry, tail_entry;
  logic          unused_bits;

  // Writes to x0 are accepted but never stored.
  assign push = alu_valid_i && alu_ready_o && !flush_i && (alu_rd_i != '0);
  assign pop  = wb_valid_o && wb_ready_i && !flush_i;

  assign alu_ready_o = (count_o != CntW'(DEPTH));
  assign wb_valid_o  = (state_q != StEmpty);

  // Pack the incoming completion, zero-extending the address.
  always_comb begin
    wr_entry              = '0;
    wr_entry.addr[ADDR_W-1:0] = alu_rd_i;
    wr_entry.data         = alu_result_i;
    wr_entry.cmp          = alu_cmp_i;
  end

  alu_wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .head_o  (head_entry),
    .tail_o  (tail_entry),
    .count_o (count_o)
  );

  // Occupancy FSM tracking the count the FIFO will hold next cycle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty:   if (push) state_d = StPartial;
        StPartial: begin
          if (push && !pop && (count_o == CntW'(DEPTH - 1)))  state_d = StFull;
          else if (pop && !push && (count_o == CntW'(1)))     state_d = StEmpty;
        end
        StFull:    if (pop) state_d = StPartial;
        default:   state_d = StEmpty;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Head entry is masked to zero while the buffer is empty.
  always_comb begin
    wb_addr_o  = '0;
    wb_wdata_o = '0;
    wb_cmp_o   = 1'b0;
    if (wb_valid_o) begin
      wb_addr_o  = head_entry.addr[ADDR_W-1:0];
      wb_wdata_o = head_entry.data;
      wb_cmp_o   = head_entry.cmp;
    end
  end

`ifdef ALU_WB_FWD_EN
  // Youngest entry wins when several share an address.
  always_comb begin
    fwd_valid_o = wb_valid_o;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    if (wb_valid_o) begin
      fwd_addr_o = tail_entry.addr[ADDR_W-1:0];
      fwd_data_o = tail_entry.data;
    end
  end
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = '0;
  assign fwd_data_o  = '0;
`endif

  // Upper address bits and unforwarded fields are intentionally unused.
  assign unused_bits = ^{head_entry.addr, tail_entry};

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed, table-driven bench for alu_wb_buffer (DEPTH=2, ADDR_W=6).
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [5:0]  alu_rd_i = '0;
  logic        alu_cmp_i = 1'b0;
  logic        alu_ready_o;
  logic        wb_valid_o;
  logic [5:0]  wb_addr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_cmp_o;
  logic        wb_ready_i = 1'b0;
  logic        fwd_valid_o;
  logic [5:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  alu_wb_buffer #(
    .DEPTH  (2),
    .ADDR_W (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .alu_valid_i  (alu_valid_i),
    .alu_result_i (alu_result_i),
    .alu_rd_i     (alu_rd_i),
    .alu_cmp_i    (alu_cmp_i),
    .alu_ready_o  (alu_ready_o),
    .wb_valid_o   (wb_valid_o),
    .wb_addr_o    (wb_addr_o),
    .wb_wdata_o   (wb_wdata_o),
    .wb_cmp_o     (wb_cmp_o),
    .wb_ready_i   (wb_ready_i),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_addr_o   (fwd_addr_o),
    .fwd_data_o   (fwd_data_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        cmp;
    logic        wb_ready;
    logic [1:0]  cnt;
    logic        wbv;
    logic [5:0]  wba;
    logic [31:0] wbd;
    logic        wbc;
    logic        rdy;
    logic        fv;
    logic [5:0]  fa;
    logic [31:0] fd;
  } vec_t;

  localparam int NumVec = 14;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [5:0] rd,
                       input logic [31:0] d, input logic c, input logic r);
    flush_i      = f;
    alu_valid_i  = v;
    alu_rd_i     = rd;
    alu_result_i = d;
    alu_cmp_i    = c;
    wb_ready_i   = r;
  endtask

  task automatic check_fwd(input string tag, input logic fv, input logic [5:0] fa,
                           input logic [31:0] fd);
`ifdef ALU_WB_FWD_EN
    check({tag, " fwd_valid"}, 32'(fwd_valid_o), 32'(fv));
    check({tag, " fwd_addr"},  32'(fwd_addr_o),  32'(fa));
    check({tag, " fwd_data"},  fwd_data_o,       fd);
`else
    check({tag, " fwd_valid"}, 32'(fwd_valid_o), 32'(1'b0));
    check({tag, " fwd_addr"},  32'(fwd_addr_o),  32'(6'd0));
    check({tag, " fwd_data"},  fwd_data_o,       32'd0);
    if (fv && (fa == 6'h3f) && (fd == 32'hffff_ffff)) check({tag, " unreachable"}, 0, 0);
`endif
  endtask

  initial begin
    //            flush valid rd    data          cmp rdy  cnt  wbv wba   wbd           wbc rdy  fv fa    fd
    vecs[0]  = '{1'b0, 1'b1, 6'd5, 32'h28,       1'b1, 1'b1, 2'd1, 1'b1, 6'd5, 32'h28, 1'b1, 1'b1, 1'b1, 6'd5, 32'h28};
    vecs[1]  = '{1'b0, 1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 6'd0, 32'hFFFF_FFF7,1'b1, 1'b0, 2'd0, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 6'd1, 32'h11,       1'b0, 1'b0, 2'd1, 1'b1, 6'd1, 32'h11, 1'b0, 1'b1, 1'b1, 6'd1, 32'h11};
    vecs[4]  = '{1'b0, 1'b1, 6'd2, 32'h22,       1'b1, 1'b0, 2'd2, 1'b1, 6'd1, 32'h11, 1'b0, 1'b0, 1'b1, 6'd2, 32'h22};
    vecs[5]  = '{1'b0, 1'b1, 6'd3, 32'h33,       1'b0, 1'b0, 2'd2, 1'b1, 6'd1, 32'h11, 1'b0, 1'b0, 1'b1, 6'd2, 32'h22};
    vecs[6]  = '{1'b0, 1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 2'd1, 1'b1, 6'd2, 32'h22, 1'b1, 1'b1, 1'b1, 6'd2, 32'h22};
    vecs[7]  = '{1'b0, 1'b1, 6'd4, 32'h44,       1'b0, 1'b1, 2'd1, 1'b1, 6'd4, 32'h44, 1'b0, 1'b1, 1'b1, 6'd4, 32'h44};
    vecs[8]  = '{1'b0, 1'b1, 6'd6, 32'h66,       1'b1, 1'b0, 2'd2, 1'b1, 6'd4, 32'h44, 1'b0, 1'b0, 1'b1, 6'd6, 32'h66};
    vecs[9]  = '{1'b1, 1'b1, 6'd9, 32'h99,       1'b1, 1'b1, 2'd0, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 6'd7, 32'h14,       1'b0, 1'b0, 2'd1, 1'b1, 6'd7, 32'h14, 1'b0, 1'b1, 1'b1, 6'd7, 32'h14};
    vecs[11] = '{1'b0, 1'b1, 6'd7, 32'h1E,       1'b1, 1'b0, 2'd2, 1'b1, 6'd7, 32'h14, 1'b0, 1'b0, 1'b1, 6'd7, 32'h1E};
    vecs[12] = '{1'b0, 1'b1, 6'd8, 32'h88,       1'b0, 1'b1, 2'd1, 1'b1, 6'd7, 32'h1E, 1'b1, 1'b1, 1'b1, 6'd7, 32'h1E};
    vecs[13] = '{1'b0, 1'b0, 6'd0, 32'h0,        1'b0, 1'b1, 2'd0, 1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 1'b0, 6'd0, 32'h0};

    // Reset values while rst_n is held low.
    #12;
    check("rst count",     32'(count_o),     32'(2'd0));
    check("rst wb_valid",  32'(wb_valid_o),  32'(1'b0));
    check("rst wb_addr",   32'(wb_addr_o),   32'(6'd0));
    check("rst wb_wdata",  wb_wdata_o,       32'd0);
    check("rst alu_ready", 32'(alu_ready_o), 32'(1'b1));
    check_fwd("rst", 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A push into an empty buffer must not show up combinationally.
    drive(1'b0, 1'b1, 6'd5, 32'h28, 1'b1, 1'b1);
    #1;
    check("latency wb_valid", 32'(wb_valid_o), 32'(1'b0));

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].flush, vecs[i].valid, vecs[i].rd, vecs[i].data, vecs[i].cmp,
            vecs[i].wb_ready);
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i),     32'(count_o),     32'(vecs[i].cnt));
      check($sformatf("v%0d wb_valid", i),  32'(wb_valid_o),  32'(vecs[i].wbv));
      check($sformatf("v%0d wb_addr", i),   32'(wb_addr_o),   32'(vecs[i].wba));
      check($sformatf("v%0d wb_wdata", i),  wb_wdata_o,       vecs[i].wbd);
      check($sformatf("v%0d wb_cmp", i),    32'(wb_cmp_o),    32'(vecs[i].wbc));
      check($sformatf("v%0d alu_ready", i), 32'(alu_ready_o), 32'(vecs[i].rdy));
      check_fwd($sformatf("v%0d", i), vecs[i].fv, vecs[i].fa, vecs[i].fd);
    end

    // Fill the buffer, then assert reset between clock edges.
    drive(1'b0, 1'b1, 6'd10, 32'hAB, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 6'd11, 32'hCD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre-rst count", 32'(count_o), 32'(2'd2));
    drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst count",     32'(count_o),     32'(2'd0));
    check("mid-rst wb_valid",  32'(wb_valid_o),  32'(1'b0));
    check("mid-rst wb_wdata",  wb_wdata_o,       32'd0);
    check("mid-rst alu_ready", 32'(alu_ready_o), 32'(1'b1));
    check_fwd("mid-rst", 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst wb_valid", 32'(wb_valid_o), 32'(1'b0));

    // Fresh push after reset must be the only entry.
    drive(1'b0, 1'b1, 6'd12, 32'h55, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
    check("post-rst count",   32'(count_o),   32'(2'd1));
    check("post-rst wb_addr", 32'(wb_addr_o), 32'(6'd12));
    check("post-rst wb_data", wb_wdata_o,     32'h55);
    check("post-rst wb_cmp",  32'(wb_cmp_o),  32'(1'b1));
    @(posedge clk);
    #1;
    check("drain count", 32'(count_o), 32'(2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of buffered result entries (legal 2..8).
REQ-002 Parameter ADDR_W, default 6, SHALL set the register-file destination address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush_i  input  1  SHALL discard all buffered entries (pipeline kill).
REQ-006 alu_valid_i  input  1  SHALL mark alu_result_i/alu_rd_i/alu_cmp_i as a valid ALU completion.
REQ-007 alu_result_i  input  32  SHALL carry the ALU result_o value.
REQ-008 alu_rd_i  input  ADDR_W  SHALL carry the destination register address.
REQ-009 alu_cmp_i  input  1  SHALL carry the ALU comparison_result_o value.
REQ-010 alu_ready_o  output  1  SHALL indicate the buffer can accept an entry this cycle.
REQ-011 wb_valid_o  output  1  SHALL indicate the head entry is presented to the register-file write port.
REQ-012 wb_addr_o, wb_wdata_o, wb_cmp_o  output  ADDR_W/32/1  SHALL carry the head entry fields.
REQ-013 wb_ready_i  input  1  SHALL indicate the write port consumes the head entry this cycle.
REQ-014 fwd_valid_o, fwd_addr_o, fwd_data_o  output  1/ADDR_W/32  SHALL expose the youngest buffered entry for operand forwarding.
REQ-015 count_o  output  $clog2(DEPTH+1)  SHALL report current occupancy.

Function
REQ-016 Push SHALL occur when alu_valid_i && alu_ready_o && !flush_i && alu_rd_i != 0; entries with alu_rd_i == 0 SHALL be accepted and silently dropped.
REQ-017 Pop SHALL occur when wb_valid_o && wb_ready_i && !flush_i.
REQ-018 alu_ready_o SHALL equal (count_o != DEPTH), independent of wb_ready_i (no full-state bypass).
REQ-019 A pushed entry SHALL appear on wb_* outputs no earlier than the next cycle (1-cycle minimum latency, no combinational input-to-output path).
REQ-020 Entries SHALL leave in push order; wb_* outputs SHALL hold stable while wb_valid_o && !wb_ready_i.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged, in any non-full state; at full no push occurs.
REQ-022 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 FSM states EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); transitions follow count_o; flush_i from any state SHALL go to EMPTY next cycle.
REQ-024 flush_i SHALL take priority over simultaneous push and pop; neither occurs in the flush cycle.
REQ-025 wb_valid_o SHALL be 1 exactly when state != EMPTY; wb_* data SHALL be 0 when EMPTY.
REQ-026 When two buffered entries share an address, fwd_* SHALL report the youngest.

Reset
REQ-027 During rst_n low: count_o=0, pointers=0, state EMPTY, wb_valid_o=0, fwd_valid_o=0, all data outputs 0, alu_ready_o=1.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, no partial writeback.

Configuration
REQ-029 Macro ALU_WB_FWD_EN defined: fwd_* SHALL reflect the youngest valid entry (fwd_valid_o = wb_valid_o).
REQ-030 Macro ALU_WB_FWD_EN undefined: fwd_valid_o, fwd_addr_o, fwd_data_o SHALL be tied 0 and no forwarding logic synthesised; ports remain.

Structure
REQ-031 Shared package cv32e40p_pkg SHALL hold typedef alu_wb_entry_t {addr, data, cmp} and constant ALU_WB_DEPTH_MAX = 8.
REQ-032 Storage and pointers SHALL live in sub-module alu_wb_entry_fifo; FSM, drop rule, and forwarding stay in alu_wb_buffer.

Verification
REQ-033 Push rd=5 data 0x0000_0028 with wb_ready_i=1 -> next cycle wb_valid_o=1, wb_addr_o=5, wb_wdata_o=0x28; following cycle EMPTY.
REQ-034 wb_ready_i=0, push 3 entries (DEPTH=2) -> third refused, alu_ready_o=0 after second, count_o=2; release wb_ready_i -> order rd1, rd2.
REQ-035 Push rd=0 data 0xFFFF_FFF7 -> alu_ready_o=1, count_o stays 0, wb_valid_o stays 0.
REQ-036 count_o=1, simultaneous push and pop -> count_o=1, new head = pushed entry.
REQ-037 count_o=2, flush_i=1 with alu_valid_i=1 -> next cycle count_o=0, wb_valid_o=0, pushed entry absent.
REQ-038 With ALU_WB_FWD_EN, push rd=7 0x14 then rd=7 0x1E (wb_ready_i=0) -> fwd_addr_o=7, fwd_data_o=0x1E; without macro fwd_valid_o=0.
